// File: rtl/lagarto_l15_req_queue_if.sv
// rtl/lagarto_l15_req_queue_if.sv - L1.5 request/return types and queue port bundle
// The type package lives here so it is always compiled ahead of the interface and the queue.
package wt_cache_pkg;
    typedef struct packed {
        logic        l15_val;
        logic        l15_req_ack;
        logic [4:0]  l15_rqtype;
        logic        l15_nc;
        logic [2:0]  l15_size;
        logic        l15_threadid;
        logic [39:0] l15_address;
        logic [63:0] l15_data;
    } l15_req_t;

    typedef struct packed {
        logic        l15_val;
        logic        l15_ack;
        logic        l15_header_ack;
        logic [3:0]  l15_returntype;
        logic [63:0] l15_data_0;
    } l15_rtrn_t;
endpackage

interface lagarto_l15_req_queue_if #(parameter int Depth = 4);
    import wt_cache_pkg::*;

    l15_req_t                 core_req_i;
    logic                     core_ready_o;
    l15_req_t                 l15_req_o;
    l15_rtrn_t                l15_rtrn_i;
    l15_rtrn_t                core_rtrn_o;
    logic [$clog2(Depth):0]   occupancy_o;
    logic                     timeout_o;

    modport slave (
        input  core_req_i, l15_rtrn_i,
        output core_ready_o, l15_req_o, core_rtrn_o, occupancy_o, timeout_o
    );

    modport master (
        output core_req_i, l15_rtrn_i,
        input  core_ready_o, l15_req_o, core_rtrn_o, occupancy_o, timeout_o
    );
endinterface

// File: rtl/lagarto_l15_req_queue.sv
// rtl/lagarto_l15_req_queue.sv - core-to-L1.5 request FIFO with return passthrough and head watchdog
// The head entry is held stable on l15_req_o until the L1.5 acks it; there is no empty bypass.
module lagarto_l15_req_queue
    import wt_cache_pkg::*;
#(
    parameter int Depth         = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    lagarto_l15_req_queue_if.slave bus
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    l15_req_t        mem_q [Depth];
    l15_req_t        entry;
    logic [PtrW-1:0] rd_q, wr_q;
    logic [CntW-1:0] cnt_q;
    logic            full, empty, push, pop;

    assign full  = (cnt_q == CntW'(Depth));
    assign empty = (cnt_q == '0);

    assign bus.core_ready_o = !full && rstn_i;
    assign push = bus.core_req_i.l15_val && bus.core_ready_o;
    assign pop  = bus.l15_rtrn_i.l15_ack && !empty;

    always_comb begin
        entry             = bus.core_req_i;
        entry.l15_req_ack = 1'b0;
    end

    // Payload storage is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_q] <= entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        bus.l15_req_o             = mem_q[rd_q];
        bus.l15_req_o.l15_val     = !empty;
        bus.l15_req_o.l15_req_ack = bus.core_req_i.l15_req_ack;
    end

    assign bus.core_rtrn_o = bus.l15_rtrn_i;
    assign bus.occupancy_o = cnt_q;

    if (TimeoutCycles == 0) begin : g_no_wd
        assign bus.timeout_o = 1'b0;
    end else begin : g_wd
        localparam int WdW = $clog2(TimeoutCycles + 1);
        logic [WdW-1:0] wd_q;
        logic           to_q;

        always_ff @(posedge clk_i) begin
            if (!rstn_i) begin
                wd_q <= '0;
                to_q <= 1'b0;
            end else begin
                if (pop || empty) begin
                    wd_q <= '0;
                end else if (wd_q != WdW'(TimeoutCycles)) begin
                    wd_q <= wd_q + 1'b1;
                end
                if (wd_q == WdW'(TimeoutCycles)) begin
                    to_q <= 1'b1;
                end
            end
        end

        assign bus.timeout_o = to_q;
    end
endmodule
